// File: rtl/spi_slave_bs.sv
// SPI mode-0 target-side byte shifter: oversamples sclk/mosi/cs_n in the system clock
// domain, delivers received bytes with a strobe and shifts queued response bytes out on miso.
module spi_slave_bs #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_byte,
    input  logic       tx_v,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic [7:0] rx_byte,
    output logic       rx_v
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic [7:0]             r_shift;
    logic [7:0]             r_hold;
    logic                   r_hold_full;
    logic [6:0]             r_rx_shift;
    logic [2:0]             r_bit_cnt;

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;
    logic w_rise;
    logic w_fall;
    logic w_load;
    logic w_abort;
    logic w_shift_fall;
    logic w_rise_act;

    // mosi shares the sclk synchronizer depth so data stays aligned with the detected edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise   = w_sclk_s & ~r_sclk_d;
    assign w_fall   = ~w_sclk_s & r_sclk_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Deselect wins over a coincident falling edge, so the final byte is never reloaded
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_cs_s) begin
                    w_state_nxt = S_ACTIVE;
                    w_load      = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_cs_s) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else if (w_fall && (r_bit_cnt == 3'd0)) begin
                    w_load = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_shift_fall = (r_state == S_ACTIVE) && !w_cs_s && w_fall && (r_bit_cnt != 3'd0);
    assign w_rise_act   = (r_state == S_ACTIVE) && !w_cs_s && w_rise;

    assign miso     = (r_state == S_ACTIVE) ? r_shift[7] : 1'b1;
    assign miso_oe  = (r_state == S_ACTIVE);
    assign tx_ready = ~r_hold_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift     <= IDLE_BYTE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rx_shift  <= '0;
            r_bit_cnt   <= '0;
            rx_byte     <= '0;
            rx_v        <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_v        <= 1'b0;
            tx_underrun <= 1'b0;

            // A load with an empty holding register lets a same-cycle tx_byte bypass straight in
            if (w_load) begin
                if (r_hold_full) begin
                    r_shift     <= r_hold;
                    r_hold_full <= 1'b0;
                end else if (tx_v) begin
                    r_shift <= tx_byte;
                end else begin
                    r_shift     <= IDLE_BYTE;
                    tx_underrun <= 1'b1;
                end
            end else begin
                if (tx_v && !r_hold_full) begin
                    r_hold      <= tx_byte;
                    r_hold_full <= 1'b1;
                end
                if (w_shift_fall) begin
                    r_shift <= {r_shift[6:0], 1'b1};
                end
            end

            if (w_abort) begin
                r_bit_cnt <= '0;
            end else if (w_rise_act) begin
                r_rx_shift <= {r_rx_shift[5:0], w_mosi_s};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    rx_byte <= {r_rx_shift, w_mosi_s};
                    rx_v    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_bs.sv
// Bench for spi_slave_bs: drives SPI mode-0 transfers, models the response path as a
// one-slot buffer, and checks rx/miso/underrun through a scoreboard monitor.
module tb_spi_slave_bs;

    logic       clock, reset, sclk, cs_n, mosi, miso, miso_oe;
    logic [7:0] tx_byte, rx_byte;
    logic       tx_v, tx_ready, tx_underrun, rx_v;

    spi_slave_bs #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_byte(tx_byte), .tx_v(tx_v),
        .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_byte(rx_byte), .rx_v(rx_v)
    );

    typedef struct {
        string       nm;
        bit          use_u;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    chk_t       chk_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];
    int         checks, errors, ucnt;
    bit         done, fin;

    // Reference model: one-slot response buffer plus expected underrun count
    bit         m_full;
    logic [7:0] m_hold;
    int         m_under;

    // Per-transfer plan
    logic [7:0] g_mo[8];
    bit         g_qen[8];
    logic [7:0] g_qv[8];
    bit         g_byp[8];
    logic [7:0] g_bv[8];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic dchk(input string nm, input logic [31:0] a, input logic [31:0] e);
        chk_t c;
        c.nm = nm; c.use_u = 1'b0; c.act = a; c.exp = e;
        chk_q.push_back(c);
    endtask

    task automatic uchk(input string nm);
        chk_t c;
        c.nm = nm; c.use_u = 1'b1; c.act = 32'd0; c.exp = 32'(m_under);
        chk_q.push_back(c);
    endtask

    task automatic model_load(input bit byp, input logic [7:0] bv, output logic [7:0] sent);
        if (m_full) begin
            sent   = m_hold;
            m_full = 1'b0;
        end else if (byp) begin
            sent = bv;
        end else begin
            sent    = 8'hFF;
            m_under = m_under + 1;
        end
    endtask

    task automatic queue_tx(input logic [7:0] v);
        dchk("tx_ready_before_write", 32'(tx_ready), 32'(!m_full));
        tx_byte = v;
        tx_v    = 1'b1;
        tick(1);
        tx_v    = 1'b0;
        if (!m_full) begin
            m_hold = v;
            m_full = 1'b1;
        end
    endtask

    task automatic clear_plan();
        for (int k = 0; k < 8; k++) begin
            g_mo[k] = 8'h00; g_qen[k] = 1'b0; g_qv[k] = 8'h00; g_byp[k] = 1'b0; g_bv[k] = 8'h00;
        end
    endtask

    // sclk = clock/16; cs_n rises together with the last falling edge
    task automatic run_xfer(input int nb, input int abort_bits);
        logic [7:0] sent;
        bit         last;
        model_load(1'b0, 8'h00, sent);
        if (abort_bits == 0) exp_tx_q.push_back(sent);
        cs_n = 1'b0;
        mosi = g_mo[0][7];
        tick(8);
        for (int b = 0; b < nb; b++) begin
            if (abort_bits == 0) exp_rx_q.push_back(g_mo[b]);
            for (int i = 0; i < 8; i++) begin
                sclk = 1'b1;
                tick(4);
                if (i == 3 && g_qen[b]) queue_tx(g_qv[b]);
                else tick(1);
                tick(3);
                last = (abort_bits != 0 && i == abort_bits - 1) || (b == nb - 1 && i == 7);
                sclk = 1'b0;
                if (last) begin
                    cs_n = 1'b1;
                    mosi = 1'b0;
                    tick(12);
                    return;
                end
                if (i < 7) begin
                    mosi = g_mo[b][6-i];
                    tick(8);
                end else begin
                    mosi = g_mo[b+1][7];
                    model_load(g_byp[b+1], g_bv[b+1], sent);
                    exp_tx_q.push_back(sent);
                    if (g_byp[b+1]) begin
                        tick(2);
                        tx_byte = g_bv[b+1];
                        tx_v    = 1'b1;
                        tick(1);
                        tx_v    = 1'b0;
                        tick(5);
                    end else begin
                        tick(8);
                    end
                end
            end
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic       sp;
        logic [7:0] mb;
        int         mc;
        chk_t       c;
        logic [7:0] e;
        logic [31:0] a;
        sp = 1'b0; mb = 8'h00; mc = 0;
        checks = 0; errors = 0; ucnt = 0; fin = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset || cs_n) begin
                mc = 0;
            end else if (sclk && !sp) begin
                mb = {mb[6:0], miso};
                mc = mc + 1;
                if (mc == 8) begin
                    mc = 0;
                    checks = checks + 1;
                    if (exp_tx_q.size() == 0) begin
                        errors = errors + 1;
                        $display("FAIL miso_byte: got %h, no byte expected", mb);
                    end else begin
                        e = exp_tx_q.pop_front();
                        if (mb !== e) begin
                            errors = errors + 1;
                            $display("FAIL miso_byte: got %h, expected %h", mb, e);
                        end
                    end
                end
            end
            sp = sclk;
            if (reset) begin
                if (tx_underrun === 1'b1) ucnt = ucnt + 1;
                if (rx_v === 1'b1) begin
                    checks = checks + 1;
                    if (exp_rx_q.size() == 0) begin
                        errors = errors + 1;
                        $display("FAIL rx_byte: unexpected rx_v with %h", rx_byte);
                    end else begin
                        e = exp_rx_q.pop_front();
                        if (rx_byte !== e) begin
                            errors = errors + 1;
                            $display("FAIL rx_byte: got %h, expected %h", rx_byte, e);
                        end
                    end
                end
            end
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                a = c.use_u ? 32'(ucnt) : c.act;
                checks = checks + 1;
                if (a !== c.exp) begin
                    errors = errors + 1;
                    $display("FAIL %s: got %0d, expected %0d", c.nm, a, c.exp);
                end
            end
            if (done && !fin) begin
                checks = checks + 1;
                if (exp_rx_q.size() != 0 || exp_tx_q.size() != 0) begin
                    errors = errors + 1;
                    $display("FAIL drain: rx left %0d, miso left %0d, expected 0 and 0",
                             exp_rx_q.size(), exp_tx_q.size());
                end
                fin = 1'b1;
            end
        end
    end

    initial begin
        logic [7:0] sent;
        int         nb, ab;
        done = 1'b0;
        m_full = 1'b0; m_hold = 8'h00; m_under = 0;
        reset = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_v = 1'b0; tx_byte = 8'h00;
        clear_plan();

        // 1: reset state
        tick(3);
        dchk("rst_miso", 32'(miso), 32'd1);
        dchk("rst_miso_oe", 32'(miso_oe), 32'd0);
        dchk("rst_tx_ready", 32'(tx_ready), 32'd1);
        dchk("rst_rx_v", 32'(rx_v), 32'd0);
        dchk("rst_rx_byte", 32'(rx_byte), 32'd0);
        reset = 1'b1;
        tick(3);

        // 2: single byte with preloaded response
        queue_tx(8'hA5);
        clear_plan(); g_mo[0] = 8'h3C;
        run_xfer(1, 0);
        uchk("underrun_single");

        // 3: three back-to-back bytes, underrun on the last boundary
        queue_tx(8'h01);
        clear_plan(); g_mo[0] = 8'h40; g_mo[1] = 8'h00; g_mo[2] = 8'h95;
        g_qen[0] = 1'b1; g_qv[0] = 8'h02;
        run_xfer(3, 0);
        uchk("underrun_b2b");

        // 4: abort after 5 bits; byte queued during the abort survives
        clear_plan(); g_mo[0] = 8'hE7; g_qen[0] = 1'b1; g_qv[0] = 8'hC3;
        run_xfer(1, 5);
        dchk("tx_ready_after_abort", 32'(tx_ready), 32'(!m_full));
        clear_plan(); g_mo[0] = 8'h81;
        run_xfer(1, 0);
        uchk("underrun_abort");

        // 5: write while full is ignored; boundary bypass
        queue_tx(8'h99);
        queue_tx(8'h55);
        clear_plan(); g_mo[0] = 8'h12; g_mo[1] = 8'h34; g_byp[1] = 1'b1; g_bv[1] = 8'h77;
        run_xfer(2, 0);
        dchk("tx_ready_after_bypass", 32'(tx_ready), 32'(!m_full));
        uchk("underrun_bypass");

        // 6: reset after bit 3
        model_load(1'b0, 8'h00, sent);
        cs_n = 1'b0; mosi = 1'b1;
        tick(8);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            tick(4);
            if (i == 1) queue_tx(8'h5A);
            else tick(1);
            tick(3);
            if (i < 2) begin
                sclk = 1'b0;
                mosi = 1'(i);
                tick(8);
            end
        end
        uchk("underrun_before_reset");
        #2 reset = 1'b0;
        #1;
        dchk("midrst_miso", 32'(miso), 32'd1);
        dchk("midrst_miso_oe", 32'(miso_oe), 32'd0);
        dchk("midrst_tx_ready", 32'(tx_ready), 32'd1);
        dchk("midrst_rx_v", 32'(rx_v), 32'd0);
        dchk("midrst_tx_underrun", 32'(tx_underrun), 32'd0);
        dchk("midrst_rx_byte", 32'(rx_byte), 32'd0);
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tick(3);
        reset = 1'b1;
        m_full = 1'b0;
        tick(5);
        clear_plan(); g_mo[0] = 8'hD2;
        run_xfer(1, 0);
        uchk("underrun_after_reset");

        // 7: randomized transfers against the model
        for (int t = 0; t < 12; t++) begin
            clear_plan();
            if ($urandom_range(0, 1) == 1) queue_tx(8'($urandom));
            nb = int'($urandom_range(1, 4));
            ab = (nb == 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            for (int b = 0; b < nb; b++) begin
                g_mo[b]  = 8'($urandom);
                g_qen[b] = ($urandom_range(0, 1) == 1);
                g_qv[b]  = 8'($urandom);
                g_byp[b] = ($urandom_range(0, 2) == 0);
                g_bv[b]  = 8'($urandom);
            end
            run_xfer(nb, ab);
            uchk("underrun_random");
            dchk("tx_ready_random", 32'(tx_ready), 32'(!m_full));
            tick(int'($urandom_range(4, 20)));
        end

        tick(10);
        done = 1'b1;
        for (int i = 0; i < 100 && !fin; i++) @(posedge clock);
        if (!fin) begin
            $display("FAIL monitor_timeout: monitor did not finish, expected finish within 100 cycles");
            $fatal(1, "monitor timeout");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_bs.md
Name: spi_slave_bs

Overview:
SPI mode-0 byte-level responder, the target-side counterpart of the SD testbench's SPI byte shifter. It lets the bench model an SPI peripheral such as an SD card. The controller-side sclk, mosi and cs_n are oversampled in the system clock domain. Received bytes are delivered with a one-cycle valid strobe, and queued response bytes are shifted out on miso MSB-first. When no response byte is queued, 0xFF is sent, which is the SD bus idle value.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on sclk, mosi and cs_n (minimum 2).
IDLE_BYTE, 8'hFF, byte shifted out when the tx holding register is empty at a byte boundary.

Ports:
clock  input  1  system clock; all logic is on posedge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
sclk  input  1  SPI clock from the controller; idles low (mode 0).
cs_n  input  1  chip select, active low.
mosi  input  1  controller-to-target data.
miso  output  1  target-to-controller data.
miso_oe  output  1  high while selected; the bench or pad tristates miso when low.
tx_byte  input  8  next response byte.
tx_v  input  1  tx_byte valid; accepted in any cycle where tx_ready=1.
tx_ready  output  1  tx holding register empty (combinational, equal to ~hold_full).
tx_underrun  output  1  one-cycle pulse when IDLE_BYTE is substituted at a byte boundary.
rx_byte  output  8  last complete received byte; holds its value until the next complete byte.
rx_v  output  1  one-cycle pulse when rx_byte updates.

Behaviour:
- Reset values: miso=1, miso_oe=0, rx_byte=0, rx_v=0, tx_underrun=0, tx_ready=1 (holding register empty), shift register=IDLE_BYTE, bit_cnt=0, state=IDLE.
- Synchronization: sclk, mosi and cs_n each pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk by comparing it with a one-flop-delayed copy. mosi goes through the same number of stages, so it stays aligned with sclk.
- Timing constraint: sclk high and low phases must each be at least SYNC_STAGES+2 clock periods. Behaviour is undefined if this is violated.
- State IDLE (synced cs_n=1):
  - miso=1, miso_oe=0, bit_cnt=0.
  - sclk edges are ignored.
- IDLE->ACTIVE on synced cs_n falling:
  - Load the shift register from the holding register if it is full (clear hold_full).
  - Otherwise load IDLE_BYTE and pulse tx_underrun.
  - If hold is empty and tx_v=1 in that same cycle, tx_byte bypasses straight into the shift register: it counts as accepted and there is no underrun.
- State ACTIVE:
  - miso = shift[7], miso_oe=1.
  - Rising sclk edge: rx_shift = {rx_shift[6:0], mosi_sync}; bit_cnt increments modulo 8.
  - When bit_cnt wraps from 7 to 0: rx_byte = {rx_shift[6:0], mosi_sync} and rx_v pulses in the same cycle the register updates.
  - Falling sclk edge with bit_cnt!=0: shift = {shift[6:0], 1'b1}.
  - Falling sclk edge with bit_cnt==0 (byte boundary): reload the shift register using the same rules (and the same bypass case) as IDLE->ACTIVE.
- ACTIVE->IDLE on synced cs_n rising, at any bit position:
  - The partial rx byte is discarded, with no rx_v.
  - bit_cnt=0.
  - Any byte loaded into the shift register but not yet fully sent is lost.
  - The holding register is kept.
- Holding register:
  - Written when tx_v && tx_ready.
  - tx_v while tx_ready=0 is ignored and does not overwrite.
  - A load event and tx_v in the same cycle with hold full: the held byte goes to the shift register and tx_v is ignored, because tx_ready was 0.
- Latency: rx_v rises SYNC_STAGES+1 clocks after the 8th raw sclk rising edge.
- Back-to-back bytes with no cs_n deassertion are supported indefinitely.
- Async reset mid-transfer returns every register to its reset value immediately. After reset is released, the first synced cs_n=0 sample produces a fresh select event.

Test Plan:
1. Reset with cs_n=1 -> miso=1, miso_oe=0, tx_ready=1, rx_v=0. Then release reset.
2. Preload tx_byte=8'hA5, drive cs_n low, shift in mosi byte 8'h3C at sclk=clock/16 -> miso bits 1,0,1,0,0,1,0,1 sampled on sclk rising edges; one rx_v pulse with rx_byte=8'h3C; no tx_underrun.
3. Three back-to-back bytes: controller sends 8'h40,8'h00,8'h95 while the bench queues 8'h01 then 8'h02 as tx_ready rises -> rx_v three times with matching rx_byte values; miso carries 8'h01,8'h02,8'hFF; tx_underrun exactly once, on the third boundary.
4. Raise cs_n after 5 rising edges, then start a new transfer of 8'h81 -> no rx_v for the partial byte; the next rx_byte is 8'h81; the held tx byte survives the abort and is sent first.
5. With hold full, pulse tx_v with 8'h55 -> ignored; hold keeps its earlier value. Then, with hold empty, assert tx_v=8'h77 in the same cycle as the boundary reload -> 8'h77 is sent with no underrun.
6. Assert reset after bit 3 of a transfer -> all outputs return to reset values that cycle; after release and a new cs_n assertion, the byte is received correctly.
